mem_arbiter: RTL and testbench

- Two-master memory arbiter. It shares the single memory port between the CPU's load/store path and a DMA/peripheral master.
- It sits between the cpu top level (mem_rd/mem_wr, address and data buses) and the memory model/SRAM.
- It sequences each access through a fixed-latency, wait-stretchable transaction and returns read data plus a one-cycle ready pulse to the owning master.
- Round-robin fairness prevents DMA from starving instruction fetch, and the reverse.

---
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-master memory arbiter between the CPU load/store path and
//               a DMA/peripheral master. It sequences each granted access
//               through a fixed-latency transaction that mem_wait can stretch.
//               It returns registered read data and a one-cycle ready pulse to
//               the owning master. Round-robin arbitration on simultaneous
//               requests keeps either master from starving the other.
//
// Ports       : clk        - single clock, rising-edge active
//               rst        - asynchronous, active-low reset
//               cpu_rd/wr  - CPU read/write request, held until cpu_ready
//               cpu_addr   - CPU access address
//               cpu_wdata  - CPU write data
//               cpu_rdata  - registered read data returned to the CPU
//               cpu_ready  - one-cycle completion pulse to the CPU
//               dma_rd/wr  - DMA read/write request, held until dma_ready
//               dma_addr   - DMA access address
//               dma_wdata  - DMA write data
//               dma_rdata  - registered read data returned to the DMA
//               dma_ready  - one-cycle completion pulse to the DMA
//               mem_addr   - address to memory (latched for the access)
//               mem_wdata  - write data to memory (latched for the access)
//               mem_rd/wr  - memory strobes, high only during ACCESS
//               mem_rdata  - memory read data, valid on the last ACCESS cycle
//               mem_wait   - memory stall, freezes the ACCESS countdown
//               grant      - one-hot owner (bit0 CPU, bit1 DMA), 0 when idle
//               err        - one-cycle pulse when the winner asks rd and wr
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,

    input  logic                  dma_rd,
    input  logic                  dma_wr,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_ready,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_wait,

    output logic [1:0]            grant,
    output logic                  err
);

    // Countdown runs from MEM_LATENCY-1 to 0; keep at least one bit.
    localparam int c_CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LATENCY - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_last_dma;   // 1: DMA won the last arbitration
    logic                  r_owner_dma;  // owner of the access in flight
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_mem_rd;
    logic                  r_mem_wr;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_dma_rdata;
    logic                  r_cpu_ready;
    logic                  r_dma_ready;
    logic [1:0]            r_grant;
    logic                  r_err;

    logic                  w_cpu_req;
    logic                  w_dma_req;
    logic                  w_any_req;
    logic                  w_pick_dma;
    logic                  w_win_rd;
    logic                  w_win_wr;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_wdata;

    // Arbitration: a lone requester wins; on a tie the master that did not
    // win last time gets the port.
    always_comb begin
        w_cpu_req   = cpu_rd | cpu_wr;
        w_dma_req   = dma_rd | dma_wr;
        w_any_req   = w_cpu_req | w_dma_req;
        w_pick_dma  = w_dma_req & (~w_cpu_req | ~r_last_dma);
        w_win_rd    = w_pick_dma ? dma_rd    : cpu_rd;
        w_win_wr    = w_pick_dma ? dma_wr    : cpu_wr;
        w_win_addr  = w_pick_dma ? dma_addr  : cpu_addr;
        w_win_wdata = w_pick_dma ? dma_wdata : cpu_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_last_dma  <= 1'b1;
            r_owner_dma <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
            r_cpu_ready <= 1'b0;
            r_dma_ready <= 1'b0;
            r_grant     <= 2'b00;
            r_err       <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for a single cycle.
            r_err       <= 1'b0;
            r_cpu_ready <= 1'b0;
            r_dma_ready <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        // Rotation advances even for an illegal request so a
                        // misbehaving master cannot keep re-winning ties.
                        r_last_dma <= w_pick_dma;
                        if (w_win_rd && w_win_wr) begin
                            r_err <= 1'b1;
                        end else begin
                            r_owner_dma <= w_pick_dma;
                            r_addr      <= w_win_addr;
                            r_wdata     <= w_win_wdata;
                            r_mem_rd    <= w_win_rd;
                            r_mem_wr    <= w_win_wr;
                            r_grant     <= w_pick_dma ? 2'b10 : 2'b01;
                            r_cnt       <= c_CNT_LOAD;
                            r_state     <= c_ST_ACCESS;
                        end
                    end
                end

                c_ST_ACCESS: begin
                    if (!mem_wait) begin
                        if (r_cnt == '0) begin
                            // Final access cycle: capture read data and hand
                            // the completion to the owner in DONE.
                            r_mem_rd <= 1'b0;
                            r_mem_wr <= 1'b0;
                            if (r_mem_rd) begin
                                if (r_owner_dma) begin
                                    r_dma_rdata <= mem_rdata;
                                end else begin
                                    r_cpu_rdata <= mem_rdata;
                                end
                            end
                            if (r_owner_dma) begin
                                r_dma_ready <= 1'b1;
                            end else begin
                                r_cpu_ready <= 1'b1;
                            end
                            r_state <= c_ST_DONE;
                        end else begin
                            r_cnt <= r_cnt - c_CNT_W'(1);
                        end
                    end
                end

                c_ST_DONE: begin
                    r_grant <= 2'b00;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_grant  <= 2'b00;
                    r_mem_rd <= 1'b0;
                    r_mem_wr <= 1'b0;
                    r_state  <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ready = r_cpu_ready;
    assign dma_rdata = r_dma_rdata;
    assign dma_ready = r_dma_ready;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign grant     = r_grant;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with
//               MEM_LATENCY=2. Inputs change 1ns after the rising edge and
//               outputs are compared at that same point against hand-computed
//               values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_AW = 32;
    localparam int c_DW = 32;

    logic            clk;
    logic            rst;
    logic            cpu_rd, cpu_wr, dma_rd, dma_wr;
    logic [c_AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [c_DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
    logic [c_DW-1:0] mem_wdata, mem_rdata;
    logic            cpu_ready, dma_ready, mem_rd, mem_wr, mem_wait, err;
    logic [1:0]      grant;

    int r_n_vec;
    int r_n_mis;

    mem_arbiter #(
        .ADDR_WIDTH  (c_AW),
        .DATA_WIDTH  (c_DW),
        .MEM_LATENCY (2)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .dma_rd    (dma_rd),
        .dma_wr    (dma_wr),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_ready (dma_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_wait  (mem_wait),
        .grant     (grant),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        r_n_vec++;
        if (got !== exp) begin
            r_n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        r_n_vec   = 0;
        r_n_mis   = 0;
        rst       = 1'b1;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        dma_rd    = 1'b0;
        dma_wr    = 1'b0;
        cpu_addr  = '0;
        dma_addr  = '0;
        cpu_wdata = '0;
        dma_wdata = '0;
        mem_rdata = '0;
        mem_wait  = 1'b0;
        #2;
        rst = 1'b0;
        #1;

        // ---- reset state ----
        check_val("rst_grant", grant, 2'b00);
        check_val("rst_mem_rd", mem_rd, 0);
        check_val("rst_mem_wr", mem_wr, 0);
        check_val("rst_cpu_ready", cpu_ready, 0);
        check_val("rst_dma_ready", dma_ready, 0);
        check_val("rst_err", err, 0);
        check_val("rst_cpu_rdata", cpu_rdata, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        tick();
        rst = 1'b1;

        // ---- CPU read at 0x10 ----
        cpu_rd    = 1'b1;
        cpu_addr  = 32'h10;
        mem_rdata = 32'hDEADBEEF;
        tick();
        check_val("t1_grant", grant, 2'b01);
        check_val("t1_mem_rd_c1", mem_rd, 1);
        check_val("t1_mem_wr_c1", mem_wr, 0);
        check_val("t1_mem_addr", mem_addr, 32'h10);
        check_val("t1_ready_c1", cpu_ready, 0);
        tick();
        check_val("t1_mem_rd_c2", mem_rd, 1);
        check_val("t1_ready_c2", cpu_ready, 0);
        tick();
        check_val("t1_mem_rd_done", mem_rd, 0);
        check_val("t1_cpu_ready", cpu_ready, 1);
        check_val("t1_dma_ready", dma_ready, 0);
        check_val("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        check_val("t1_grant_done", grant, 2'b01);
        cpu_rd = 1'b0;
        tick();
        check_val("t1_ready_off", cpu_ready, 0);
        check_val("t1_grant_idle", grant, 2'b00);

        // ---- continuous contention after reset: CPU, DMA, CPU, DMA ----
        do_reset();
        cpu_rd    = 1'b1;
        cpu_addr  = 32'h100;
        dma_rd    = 1'b1;
        dma_addr  = 32'h200;
        mem_rdata = 32'h0000A5A5;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("t2_grant", grant, (i % 2 == 0) ? 2'b01 : 2'b10);
            check_val("t2_addr", mem_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
            tick();
            tick();
            check_val("t2_cpu_ready", cpu_ready, (i % 2 == 0) ? 1 : 0);
            check_val("t2_dma_ready", dma_ready, (i % 2 == 0) ? 0 : 1);
            tick();
            check_val("t2_grant_idle", grant, 2'b00);
        end
        cpu_rd = 1'b0;
        dma_rd = 1'b0;
        check_val("t2_dma_rdata", dma_rdata, 32'h0000A5A5);

        // ---- DMA write with three wait cycles ----
        dma_wr    = 1'b1;
        dma_addr  = 32'h20;
        dma_wdata = 32'h12345678;
        mem_rdata = 32'hFFFF0000;
        tick();
        for (int j = 0; j < 5; j++) begin
            mem_wait = (j < 3);
            check_val("t3_mem_wr", mem_wr, 1);
            check_val("t3_mem_rd", mem_rd, 0);
            check_val("t3_mem_addr", mem_addr, 32'h20);
            check_val("t3_mem_wdata", mem_wdata, 32'h12345678);
            check_val("t3_ready_early", dma_ready, 0);
            tick();
        end
        check_val("t3_mem_wr_done", mem_wr, 0);
        check_val("t3_dma_ready", dma_ready, 1);
        check_val("t3_cpu_ready", cpu_ready, 0);
        check_val("t3_dma_rdata", dma_rdata, 32'h0000A5A5);
        dma_wr   = 1'b0;
        mem_wait = 1'b1;  // ignored outside ACCESS
        tick();
        check_val("t3_ready_off", dma_ready, 0);
        check_val("t3_idle_grant", grant, 2'b00);
        mem_wait = 1'b0;

        // ---- illegal CPU rd+wr, then a normal DMA read ----
        cpu_rd = 1'b1;
        cpu_wr = 1'b1;
        tick();
        check_val("t4_err", err, 1);
        check_val("t4_mem_rd", mem_rd, 0);
        check_val("t4_mem_wr", mem_wr, 0);
        check_val("t4_grant", grant, 2'b00);
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        dma_rd    = 1'b1;
        dma_addr  = 32'h30;
        mem_rdata = 32'h0BADF00D;
        tick();
        check_val("t4_err_off", err, 0);
        check_val("t4_dma_grant", grant, 2'b10);
        check_val("t4_dma_mem_rd", mem_rd, 1);
        tick();
        tick();
        check_val("t4_dma_ready", dma_ready, 1);
        check_val("t4_cpu_ready", cpu_ready, 0);
        check_val("t4_dma_rdata", dma_rdata, 32'h0BADF00D);
        dma_rd = 1'b0;
        tick();

        // ---- reset during a CPU read ----
        cpu_rd    = 1'b1;
        cpu_addr  = 32'h50;
        mem_rdata = 32'h55555555;
        tick();
        check_val("t5_mem_rd", mem_rd, 1);
        #2;
        rst = 1'b0;
        #1;
        check_val("t5_mem_rd_rst", mem_rd, 0);
        check_val("t5_grant_rst", grant, 2'b00);
        check_val("t5_addr_rst", mem_addr, 0);
        check_val("t5_cpu_rdata_rst", cpu_rdata, 0);
        check_val("t5_dma_rdata_rst", dma_rdata, 0);
        tick();
        rst    = 1'b1;
        cpu_rd = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("t5_no_ready", cpu_ready, 0);
            check_val("t5_no_grant", grant, 2'b00);
        end
        cpu_rd   = 1'b1;
        dma_rd   = 1'b1;
        cpu_addr = 32'h60;
        tick();
        check_val("t5_tie_grant", grant, 2'b01);
        tick();
        tick();
        check_val("t5_cpu_ready", cpu_ready, 1);
        cpu_rd = 1'b0;
        dma_rd = 1'b0;
        tick();

        // ---- requester changes address and drops rd mid-access ----
        cpu_rd    = 1'b1;
        cpu_addr  = 32'h40;
        mem_rdata = 32'hCAFE0040;
        tick();
        check_val("t6_addr_c1", mem_addr, 32'h40);
        cpu_addr = 32'h99;
        cpu_rd   = 1'b0;
        tick();
        check_val("t6_addr_c2", mem_addr, 32'h40);
        check_val("t6_mem_rd_c2", mem_rd, 1);
        tick();
        check_val("t6_cpu_ready", cpu_ready, 1);
        check_val("t6_cpu_rdata", cpu_rdata, 32'hCAFE0040);
        tick();
        check_val("t6_ready_off", cpu_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", r_n_vec, r_n_mis);
        $finish;
    end

endmodule
`default_nettype wire
